// File: rtl/ncl_pkg.sv
// Shared dual-rail codes, channel state encoding and pair decode for ncl_ctl_array.
package ncl_pkg;

  // Pair codes as {t, f}
  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_TRUE    = 2'b10;
  localparam logic [1:0] DR_FALSE   = 2'b01;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    S_NULL,
    S_PART,
    S_DATA,
    S_DRAIN,
    S_ERR
  } ncl_state_e;

  typedef struct packed {
    logic is_null;
    logic is_data;
    logic is_true;
    logic is_ill;
  } pair_dec_t;

  function automatic pair_dec_t pair_decode(input logic t, input logic f);
    pair_dec_t d;
    d.is_null = ({t, f} == DR_NULL);
    d.is_data = ({t, f} == DR_TRUE) || ({t, f} == DR_FALSE);
    d.is_true = ({t, f} == DR_TRUE);
    d.is_ill  = ({t, f} == DR_ILLEGAL);
    return d;
  endfunction

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_TRUE : DR_FALSE;
  endfunction

endpackage

// File: rtl/ncl_ctl_chan.sv
// One dual-rail phase-controller channel: wavefront FSM, partial-wavefront timeout,
// latched r_c/r_m outputs, completion acknowledge and sticky illegal/timeout error.
module ncl_ctl_chan
  import ncl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ph0_t_i,
  input  logic ph0_f_i,
  input  logic ph1_t_i,
  input  logic ph1_f_i,
  input  logic rd_t_i,
  input  logic rd_f_i,
  input  logic ld_t_i,
  input  logic ld_f_i,
  input  logic err_clr_i,
  output logic r_c_t_o,
  output logic r_c_f_o,
  output logic r_m_t_o,
  output logic r_m_f_o,
  output logic ko_o,
  output logic err_o
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT >= 2) ? TIMEOUT - 2 : 0);

  ncl_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      rc_q, rm_q;
  logic            ko_q, err_q;

  pair_dec_t d_ph0, d_ph1, d_rd, d_ld;
  logic      all_null, any_null, complete, illegal, partial;
  logic      rc_true, rm_true, timeout_now, err_set;

  always_comb begin
    d_ph0    = pair_decode(ph0_t_i, ph0_f_i);
    d_ph1    = pair_decode(ph1_t_i, ph1_f_i);
    d_rd     = pair_decode(rd_t_i, rd_f_i);
    d_ld     = pair_decode(ld_t_i, ld_f_i);
    all_null = d_ph0.is_null & d_ph1.is_null & d_rd.is_null & d_ld.is_null;
    any_null = d_ph0.is_null | d_ph1.is_null | d_rd.is_null | d_ld.is_null;
    complete = d_ph0.is_data & d_ph1.is_data & d_rd.is_data & d_ld.is_data;
    illegal  = d_ph0.is_ill | d_ph1.is_ill | d_rd.is_ill | d_ld.is_ill;
    partial  = ~all_null & ~complete & ~illegal;
    // Only meaningful when complete, where "not TRUE" means FALSE.
    rc_true  = ~d_ph0.is_true & d_ph1.is_true & d_rd.is_true;
    rm_true  = d_ph0.is_true | (d_ph1.is_true & d_ld.is_true);
    // The S_NULL->S_PART edge is the first partial sample, so S_PART errors when the
    // count entering the edge is TIMEOUT-2 (and increments to TIMEOUT-1 on that edge).
    timeout_now = partial &
                  (((state_q == S_NULL) && (TIMEOUT == 1)) ||
                   ((state_q == S_PART) && (TIMEOUT >= 2) && (cnt_q == CntLast)));
    err_set  = illegal | timeout_now;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_NULL;
      cnt_q   <= '0;
      rc_q    <= DR_NULL;
      rm_q    <= DR_NULL;
      ko_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      // Set beats clear when both occur on the same edge.
      err_q <= err_set | (err_q & ~err_clr_i);
      if (err_set) begin
        state_q <= S_ERR;
        rc_q    <= DR_NULL;
        rm_q    <= DR_NULL;
        ko_q    <= 1'b0;
      end else begin
        unique case (state_q)
          S_NULL, S_PART: begin
            if (complete) begin
              state_q <= S_DATA;
              rc_q    <= dr_encode(rc_true);
              rm_q    <= dr_encode(rm_true);
              ko_q    <= 1'b0;
            end else if (all_null) begin
              state_q <= S_NULL;
            end else if (state_q == S_NULL) begin
              state_q <= S_PART;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          S_DATA: begin
            if (any_null) state_q <= S_DRAIN;
          end
          S_DRAIN, S_ERR: begin
            if (all_null) begin
              state_q <= S_NULL;
              rc_q    <= DR_NULL;
              rm_q    <= DR_NULL;
              ko_q    <= 1'b1;
            end
          end
          default: begin
            state_q <= S_NULL;
            rc_q    <= DR_NULL;
            rm_q    <= DR_NULL;
            ko_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign r_c_t_o = rc_q[1];
  assign r_c_f_o = rc_q[0];
  assign r_m_t_o = rm_q[1];
  assign r_m_f_o = rm_q[0];
  assign ko_o    = ko_q;
  assign err_o   = err_q;

endmodule

// File: rtl/ncl_ctl_array.sv
// CH independent dual-rail phase-controller channels. Defining NCL_INPUT_SYNC_EN adds a
// 2-flop synchronizer on every input rail (err_clr excluded).
module ncl_ctl_array
  import ncl_pkg::*;
#(
  parameter int unsigned CH      = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] ph0_t,
  input  logic [CH-1:0] ph0_f,
  input  logic [CH-1:0] ph1_t,
  input  logic [CH-1:0] ph1_f,
  input  logic [CH-1:0] rd_t,
  input  logic [CH-1:0] rd_f,
  input  logic [CH-1:0] ld_t,
  input  logic [CH-1:0] ld_f,
  input  logic [CH-1:0] err_clr,
  output logic [CH-1:0] r_c_t,
  output logic [CH-1:0] r_c_f,
  output logic [CH-1:0] r_m_t,
  output logic [CH-1:0] r_m_f,
  output logic [CH-1:0] ko,
  output logic [CH-1:0] err
);

  logic [8*CH-1:0] rails_raw, rails;
  logic [CH-1:0]   s_ph0_t, s_ph0_f, s_ph1_t, s_ph1_f, s_rd_t, s_rd_f, s_ld_t, s_ld_f;

  assign rails_raw = {ph0_t, ph0_f, ph1_t, ph1_f, rd_t, rd_f, ld_t, ld_f};

`ifdef NCL_INPUT_SYNC_EN
  logic [8*CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rails_raw;
      sync2_q <= sync1_q;
    end
  end

  assign rails = sync2_q;
`else
  assign rails = rails_raw;
`endif

  assign {s_ph0_t, s_ph0_f, s_ph1_t, s_ph1_f, s_rd_t, s_rd_f, s_ld_t, s_ld_f} = rails;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    ncl_ctl_chan #(
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .ph0_t_i   (s_ph0_t[i]),
      .ph0_f_i   (s_ph0_f[i]),
      .ph1_t_i   (s_ph1_t[i]),
      .ph1_f_i   (s_ph1_f[i]),
      .rd_t_i    (s_rd_t[i]),
      .rd_f_i    (s_rd_f[i]),
      .ld_t_i    (s_ld_t[i]),
      .ld_f_i    (s_ld_f[i]),
      .err_clr_i (err_clr[i]),
      .r_c_t_o   (r_c_t[i]),
      .r_c_f_o   (r_c_f[i]),
      .r_m_t_o   (r_m_t[i]),
      .r_m_f_o   (r_m_f[i]),
      .ko_o      (ko[i]),
      .err_o     (err[i])
    );
  end

endmodule
